// File: rtl/ppd_commutator.sv
// Serial-to-parallel input commutator for the polyphase decimation filter.
// Optional frame re-alignment input i_sync is enabled by defining PPD_COMM_SYNC_EN.
module ppd_commutator #(
    parameter int gp_idata_width       = 6,
    parameter int gp_decimation_factor = 31,
    parameter int gp_ccw               = 1,
    localparam int LP_PW = (gp_decimation_factor > 1) ? $clog2(gp_decimation_factor) : 1
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_ena,
`ifdef PPD_COMM_SYNC_EN
    input  logic                                           i_sync,
`endif
    input  logic [gp_idata_width-1:0]                      i_data,
    output logic [gp_decimation_factor*gp_idata_width-1:0] o_data,
    output logic                                           o_valid,
    output logic [LP_PW-1:0]                               o_phase
);

    localparam int W = gp_idata_width;
    localparam int D = gp_decimation_factor;

    logic [LP_PW-1:0] r_phase;
    logic [D*W-1:0]   r_buf;
    logic [D*W-1:0]   r_data;
    logic             r_valid;

    logic [LP_PW-1:0] w_phase_eff;
    logic [D*W-1:0]   w_buf_next;
    logic             w_last;
    logic             w_sync;
    int               w_lane;

`ifdef PPD_COMM_SYNC_EN
    assign w_sync = i_sync;
`else
    assign w_sync = 1'b0;
`endif

    // A sync with a sample restarts the frame at phase 0.
    always_comb begin
        w_phase_eff = (w_sync && i_ena) ? '0 : r_phase;
        w_last      = (w_phase_eff == LP_PW'(D - 1));
        w_lane      = (gp_ccw != 0) ? (D - 1 - int'(w_phase_eff)) : int'(w_phase_eff);
        w_buf_next  = r_buf;
        for (int j = 0; j < D; j++) begin
            if (j == w_lane) begin
                w_buf_next[j*W +: W] = i_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= '0;
            r_buf   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_ena) begin
                r_buf <= w_buf_next;
                if (w_last) begin
                    r_phase <= '0;
                    r_data  <= w_buf_next;
                    r_valid <= 1'b1;
                end else begin
                    r_phase <= w_phase_eff + 1'b1;
                end
            end else if (w_sync) begin
                r_phase <= '0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_phase = r_phase;

endmodule

// File: tb/tb_ppd_commutator.sv
// Directed bench for ppd_commutator: CCW/CW D=4 and D=1 instances on shared stimulus.
module tb_ppd_commutator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        sync = 1'b0;
    logic [5:0]  data = '0;

    logic [23:0] ccw_data;
    logic        ccw_valid;
    logic [1:0]  ccw_phase;
    logic [23:0] cw_data;
    logic        cw_valid;
    logic [1:0]  cw_phase;
    logic [5:0]  d1_data;
    logic        d1_valid;
    logic [0:0]  d1_phase;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(4), .gp_ccw(1)) u_ccw (
        .i_clk(clk), .i_rst(rst), .i_ena(ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(sync),
`endif
        .i_data(data), .o_data(ccw_data), .o_valid(ccw_valid), .o_phase(ccw_phase)
    );

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(4), .gp_ccw(0)) u_cw (
        .i_clk(clk), .i_rst(rst), .i_ena(ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(1'b0),
`endif
        .i_data(data), .o_data(cw_data), .o_valid(cw_valid), .o_phase(cw_phase)
    );

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(1), .gp_ccw(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(1'b0),
`endif
        .i_data(data), .o_data(d1_data), .o_valid(d1_valid), .o_phase(d1_phase)
    );

    task automatic step(input logic e, input logic [5:0] d);
        @(negedge clk);
        ena  = e;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step(1'b0, 6'd0);
        step(1'b1, 6'd9);
        rst = 1'b0;
        chk("rst_ccw_data", 64'(ccw_data), 64'd0);
        chk("rst_ccw_valid", 64'(ccw_valid), 64'd0);
        chk("rst_ccw_phase", 64'(ccw_phase), 64'd0);
        chk("rst_cw_data", 64'(cw_data), 64'd0);
        chk("rst_d1_valid", 64'(d1_valid), 64'd0);

        // ordering: 1,2,3,4
        step(1'b1, 6'd1);
        chk("ph1", 64'(ccw_phase), 64'd1);
        chk("d1_first", 64'(d1_data), 64'd1);
        step(1'b1, 6'd2);
        step(1'b1, 6'd3);
        chk("ph3", 64'(ccw_phase), 64'd3);
        chk("pre_valid", 64'(ccw_valid), 64'd0);
        step(1'b1, 6'd4);
        chk("ccw_valid", 64'(ccw_valid), 64'd1);
        chk("ccw_frame", 64'(ccw_data), 64'({6'd1, 6'd2, 6'd3, 6'd4}));
        chk("cw_frame", 64'(cw_data), 64'({6'd4, 6'd3, 6'd2, 6'd1}));
        chk("ph_wrap", 64'(ccw_phase), 64'd0);
        step(1'b0, 6'd0);
        chk("ccw_pulse_end", 64'(ccw_valid), 64'd0);
        chk("ccw_hold", 64'(ccw_data), 64'({6'd1, 6'd2, 6'd3, 6'd4}));
        chk("d1_idle", 64'(d1_valid), 64'd0);

        // bit-exact extremes: -1,-32,31,0
        step(1'b1, 6'h3F);
        step(1'b1, 6'h20);
        step(1'b1, 6'h1F);
        step(1'b1, 6'h00);
        chk("cw_exact", 64'(cw_data), 64'({6'h00, 6'h1F, 6'h20, 6'h3F}));
        chk("ccw_exact", 64'(ccw_data), 64'({6'h3F, 6'h20, 6'h1F, 6'h00}));

        // gapped input 5..12
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 6'(5 + i));
            pulses += int'(ccw_valid);
            if (i == 3) begin
                chk("gap_frame1", 64'(ccw_data), 64'({6'd5, 6'd6, 6'd7, 6'd8}));
            end
            step(1'b0, 6'd0);
            pulses += int'(ccw_valid);
            if (i == 5) begin
                chk("gap_hold", 64'(ccw_data), 64'({6'd5, 6'd6, 6'd7, 6'd8}));
            end
        end
        chk("gap_pulses", 64'(pulses), 64'd2);
        chk("gap_frame2", 64'(ccw_data), 64'({6'd9, 6'd10, 6'd11, 6'd12}));

        // reset mid-frame
        step(1'b1, 6'd1);
        step(1'b1, 6'd2);
        rst = 1'b1;
        step(1'b1, 6'd33);
        rst = 1'b0;
        chk("mid_rst_phase", 64'(ccw_phase), 64'd0);
        chk("mid_rst_data", 64'(ccw_data), 64'd0);
        step(1'b1, 6'd7);
        step(1'b1, 6'd8);
        step(1'b1, 6'd9);
        chk("mid_rst_novalid", 64'(ccw_valid), 64'd0);
        step(1'b1, 6'd10);
        chk("mid_rst_valid", 64'(ccw_valid), 64'd1);
        chk("mid_rst_frame", 64'(ccw_data), 64'({6'd7, 6'd8, 6'd9, 6'd10}));

        // D=1 stream 3,-3,0
        step(1'b1, 6'd3);
        chk("d1_v0", 64'(d1_valid), 64'd1);
        chk("d1_s0", 64'(d1_data), 64'h03);
        step(1'b1, 6'h3D);
        chk("d1_v1", 64'(d1_valid), 64'd1);
        chk("d1_s1", 64'(d1_data), 64'h3D);
        step(1'b1, 6'd0);
        chk("d1_v2", 64'(d1_valid), 64'd1);
        chk("d1_s2", 64'(d1_data), 64'h00);
        chk("d1_phase", 64'(d1_phase), 64'd0);
        step(1'b0, 6'd5);
        chk("d1_v3", 64'(d1_valid), 64'd0);

`ifdef PPD_COMM_SYNC_EN
        rst = 1'b1;
        step(1'b0, 6'd0);
        rst = 1'b0;
        step(1'b1, 6'd1);
        step(1'b1, 6'd2);
        sync = 1'b1;
        step(1'b1, 6'd20);
        sync = 1'b0;
        chk("sync_phase", 64'(ccw_phase), 64'd1);
        chk("sync_novalid", 64'(ccw_valid), 64'd0);
        step(1'b1, 6'd21);
        step(1'b1, 6'd22);
        chk("sync_novalid2", 64'(ccw_valid), 64'd0);
        step(1'b1, 6'd23);
        chk("sync_valid", 64'(ccw_valid), 64'd1);
        chk("sync_frame", 64'(ccw_data), 64'({6'd20, 6'd21, 6'd22, 6'd23}));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
